// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit retired per clock.
// Unsigned operands use plain shift-add; signed operands use radix-2 Booth recoding.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH:0]     r_acc;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_mul;
   logic               r_sgn;
   logic               r_prev;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_p;

   logic               w_last;
   logic               w_add;
   logic               w_sub;
   logic [WIDTH:0]     w_a_ext;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_acc_sh;
   logic [WIDTH-1:0]   w_mul_sh;

   assign w_last    = (r_cnt == CW'(WIDTH - 1));
   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign p         = r_p;

   // Booth pair (b[i], b[i-1]): 01 adds, 10 subtracts; unsigned mode just adds on a 1 bit.
   always_comb begin
      w_a_ext  = r_sgn ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
      w_add    = r_sgn ? (~r_mul[0] & r_prev) : r_mul[0];
      w_sub    = r_sgn & r_mul[0] & ~r_prev;
      w_sum    = r_acc;
      if (w_add)
         w_sum = r_acc + w_a_ext;
      else if (w_sub)
         w_sum = r_acc - w_a_ext;
      w_acc_sh = {r_sgn & w_sum[WIDTH], w_sum[WIDTH:1]};
      w_mul_sh = {w_sum[0], r_mul[WIDTH-1:1]};
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = CALC;
         CALC:    if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc  <= '0;
         r_a    <= '0;
         r_mul  <= '0;
         r_sgn  <= 1'b0;
         r_prev <= 1'b0;
         r_cnt  <= '0;
         r_p    <= '0;
      end else if (r_state == IDLE) begin
         if (in_valid) begin
            r_a    <= a;
            r_mul  <= b;
            r_sgn  <= signed_mode;
            r_acc  <= '0;
            r_prev <= 1'b0;
            r_cnt  <= '0;
         end
      end else if (r_state == CALC) begin
         r_acc  <= w_acc_sh;
         r_mul  <= w_mul_sh;
         r_prev <= r_mul[0];
         r_cnt  <= r_cnt + 1'b1;
         if (w_last)
            r_p <= {w_acc_sh[WIDTH-1:0], w_mul_sh};
      end
   end

endmodule
